// File: rtl/soc2_ram_arbiter_if.sv
// Avalon-MM requester port bundle used by soc2_ram_arbiter.
// Signals: address/byteenable/read/write/writedata in; waitrequest/readdata/readdatavalid back.
interface soc2_ram_arbiter_if;
  logic [13:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/soc2_ram_arbiter.sv
// Round-robin arbiter sharing one single-port 32-bit RAM between m0 (CPU) and m1 (DMA).
// Ports: clk, reset_n (sync, active-low); m0/m1 requester bundles (slave modport);
// ram_* drive the RAM port, ram_readdata returns one cycle after a read.
// Optional: define SOC2_RAM_ARB_BOUNDS_CHECK_EN to block accesses at address >= DEPTH.
module soc2_ram_arbiter #(
  parameter int          DEPTH    = 10240,
  parameter logic [31:0] OOR_DATA = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  soc2_ram_arbiter_if.slave      m0,
  soc2_ram_arbiter_if.slave      m1,
  output logic [13:0]            ram_address,
  output logic [3:0]             ram_byteenable,
  output logic                   ram_chipselect,
  output logic                   ram_write,
  output logic [31:0]            ram_writedata,
  output logic                   ram_clken,
  input  logic [31:0]            ram_readdata
);

  logic        r_rr_ptr;
  logic        r_rd_pend;
  logic        r_rd_owner;
  logic        r_rd_oor;

  logic        w_act0;
  logic        w_act1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_any;
  logic        w_win;
  logic        w_wr;
  logic        w_oor;
  logic [13:0] w_addr;
  logic [31:0] w_rdata;

  assign w_act0 = m0.read | m0.write;
  assign w_act1 = m1.read | m1.write;

  // No grants while reset is held; rr_ptr breaks ties only.
  assign w_gnt0 = reset_n & w_act0 & (~w_act1 | ~r_rr_ptr);
  assign w_gnt1 = reset_n & w_act1 & (~w_act0 |  r_rr_ptr);
  assign w_any  = w_gnt0 | w_gnt1;
  assign w_win  = w_gnt1;

  assign m0.waitrequest = ~reset_n | (w_act0 & ~w_gnt0);
  assign m1.waitrequest = ~reset_n | (w_act1 & ~w_gnt1);

  assign w_addr = w_win ? m1.address : m0.address;
  // Read+write together is taken as a write.
  assign w_wr   = w_win ? m1.write   : m0.write;

`ifdef SOC2_RAM_ARB_BOUNDS_CHECK_EN
  assign w_oor = (w_addr >= 14'(DEPTH));
`else
  assign w_oor = 1'b0;
`endif

  assign ram_address    = w_addr;
  assign ram_byteenable = w_win ? m1.byteenable : m0.byteenable;
  assign ram_writedata  = w_win ? m1.writedata  : m0.writedata;
  assign ram_chipselect = w_any & ~w_oor;
  assign ram_write      = w_any & w_wr & ~w_oor;
  assign ram_clken      = reset_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr_ptr   <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
      r_rd_oor   <= 1'b0;
    end else begin
      if (w_any) begin
        r_rr_ptr <= ~w_win;
      end
      r_rd_pend <= w_any & ~w_wr;
      if (w_any & ~w_wr) begin
        r_rd_owner <= w_win;
        r_rd_oor   <= w_oor;
      end
    end
  end

  assign w_rdata = r_rd_oor ? OOR_DATA : ram_readdata;

  // Gating with reset_n drops a read that was pending when reset hit.
  assign m0.readdatavalid = reset_n & r_rd_pend & ~r_rd_owner;
  assign m1.readdatavalid = reset_n & r_rd_pend &  r_rd_owner;
  assign m0.readdata      = w_rdata;
  assign m1.readdata      = w_rdata;

endmodule

// File: tb/tb_soc2_ram_arbiter.sv
// Self-checking bench for soc2_ram_arbiter: RAM model, cycle model, directed vectors.
// Honours SOC2_RAM_ARB_BOUNDS_CHECK_EN the same way as the design.
module tb_soc2_ram_arbiter;
  localparam int          DEPTH = 10240;
  localparam logic [31:0] OOR   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic        ram_clken;
  logic [31:0] ram_readdata;

  soc2_ram_arbiter_if m0_if ();
  soc2_ram_arbiter_if m1_if ();

  soc2_ram_arbiter #(.DEPTH(DEPTH), .OOR_DATA(OOR)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .ram_address    (ram_address),
    .ram_byteenable (ram_byteenable),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata)
  );

  always #5 clk = ~clk;

  // RAM stand-in: 16K deep so undecoded high addresses still land somewhere.
  logic [31:0] ram [0:16383];
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= ram[ram_address];
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, a, e);
  endtask

  // Reference model: expected memory image, preferred requester, expected return.
  logic [31:0] exp_mem [0:16383];
  logic        m_pref;
  logic        m_pend;
  logic        m_owner;
  logic [31:0] m_data;
  int          wcnt0;
  int          wcnt1;

  always @(negedge clk) begin
    logic a0, a1, win, any, wr, oor;
    logic [13:0] ad;
    logic [3:0]  be;
    logic [31:0] wd;
    if (!reset_n) begin
      chk("rst_wait0", m0_if.waitrequest, 1);
      chk("rst_wait1", m1_if.waitrequest, 1);
      chk("rst_cs", ram_chipselect, 0);
      chk("rst_wr", ram_write, 0);
      chk("rst_rdv0", m0_if.readdatavalid, 0);
      chk("rst_rdv1", m1_if.readdatavalid, 0);
      chk("rst_clken", ram_clken, 0);
      m_pref = 1'b0;
      m_pend = 1'b0;
      wcnt0 = 0;
      wcnt1 = 0;
    end else begin
      a0  = m0_if.read | m0_if.write;
      a1  = m1_if.read | m1_if.write;
      any = a0 | a1;
      win = (a0 && a1) ? m_pref : a1;
      chk("wait0", m0_if.waitrequest, a0 && !(any && !win));
      chk("wait1", m1_if.waitrequest, a1 && !(any && win));
      chk("rdv0", m0_if.readdatavalid, m_pend && !m_owner);
      chk("rdv1", m1_if.readdatavalid, m_pend && m_owner);
      if (m_pend)
        chk("rdata", m_owner ? m1_if.readdata : m0_if.readdata, m_data);
      chk("clken", ram_clken, 1);
      wcnt0 = m0_if.waitrequest ? wcnt0 + 1 : 0;
      wcnt1 = m1_if.waitrequest ? wcnt1 + 1 : 0;
      if (a0) chk("fair0", wcnt0 > 1, 0);
      if (a1) chk("fair1", wcnt1 > 1, 0);
      ad = win ? m1_if.address    : m0_if.address;
      be = win ? m1_if.byteenable : m0_if.byteenable;
      wd = win ? m1_if.writedata  : m0_if.writedata;
      wr = win ? m1_if.write      : m0_if.write;
`ifdef SOC2_RAM_ARB_BOUNDS_CHECK_EN
      oor = (int'(ad) >= DEPTH);
`else
      oor = 1'b0;
`endif
      chk("cs", ram_chipselect, any && !oor);
      chk("ram_wr", ram_write, any && wr && !oor);
      if (any && !oor) begin
        chk("ram_addr", ram_address, ad);
        if (wr) begin
          chk("ram_be", ram_byteenable, be);
          chk("ram_wd", ram_writedata, wd);
        end
      end
      m_pend = any && !wr;
      if (any) begin
        m_pref = !win;
        if (wr && !oor) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) exp_mem[ad][8*b +: 8] = wd[8*b +: 8];
        end else if (!wr) begin
          m_owner = win;
          m_data  = oor ? OOR : exp_mem[ad];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int who, input logic rd, input logic wr,
                     input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
    if (who == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
      m0_if.writedata = d; m0_if.byteenable = be;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
      m1_if.writedata = d; m1_if.byteenable = be;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ram[i] = 32'h0;
      exp_mem[i] = 32'h0;
    end
    ram_readdata = 32'h0;
    m_pref = 1'b0; m_pend = 1'b0; m_owner = 1'b0; m_data = 32'h0;
    wcnt0 = 0; wcnt1 = 0;
    reset_n = 1'b0;
    drv(0, 1, 0, 14'h0, 32'h0, 4'hF);
    drv(1, 0, 0, 14'h0, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    step(); reset_n = 1'b1;
    @(negedge clk);
    chk("lit_rel_gnt0", m0_if.waitrequest, 0);
    chk("lit_rel_cs", ram_chipselect, 1);
    step(); drv(0, 0, 1, 14'h0010, 32'hA5A5_1234, 4'hF);
    @(negedge clk);
    chk("lit_rd0_rdv", m0_if.readdatavalid, 1);
    chk("lit_rd0_data", m0_if.readdata, 32'h0);
    step(); drv(0, 1, 0, 14'h0010, 32'h0, 4'hF);
    step(); drv(0, 0, 0, 14'h0, 32'h0, 4'hF);
    @(negedge clk);
    chk("lit_wr_rd_rdv", m0_if.readdatavalid, 1);
    chk("lit_wr_rd_data", m0_if.readdata, 32'hA5A5_1234);
    chk("lit_m1_no_rdv", m1_if.readdatavalid, 0);
    step(); drv(0, 1, 0, 14'h0010, 32'h0, 4'hF);
    step(); drv(0, 0, 1, 14'h0010, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    chk("lit_rd_wr_old", m0_if.readdata, 32'hA5A5_1234);
    step(); drv(0, 1, 0, 14'h0010, 32'h0, 4'hF);
    step(); drv(0, 0, 0, 14'h0, 32'h0, 4'hF);
    @(negedge clk);
    chk("lit_new_data", m0_if.readdata, 32'hDEAD_BEEF);
    step(); drv(0, 0, 1, 14'd5, 32'hFFFF_FFFF, 4'hF);
    step(); drv(0, 0, 1, 14'd5, 32'h0000_00AB, 4'b0001);
    step(); drv(0, 1, 0, 14'd5, 32'h0, 4'hF);
    step(); drv(0, 0, 0, 14'h0, 32'h0, 4'hF);
    @(negedge clk);
    chk("lit_bytelane", m0_if.readdata, 32'hFFFF_FFAB);
    step(); drv(0, 0, 1, 14'd1, 32'd11, 4'hF);
    step(); drv(0, 0, 1, 14'd2, 32'd22, 4'hF);
    step(); drv(0, 0, 0, 14'h0, 32'h0, 4'hF);
    step(); drv(1, 1, 0, 14'd2, 32'h0, 4'hF);
    @(negedge clk);
    chk("lit_m1_gnt", m1_if.waitrequest, 0);
    step(); drv(1, 0, 0, 14'h0, 32'h0, 4'hF); reset_n = 1'b0;
    @(negedge clk);
    chk("lit_rst_rdv1", m1_if.readdatavalid, 0);
    step();
    step(); reset_n = 1'b1;
    drv(0, 1, 0, 14'd1, 32'h0, 4'hF);
    drv(1, 1, 0, 14'd2, 32'h0, 4'hF);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("lit_alt_w0", m0_if.waitrequest, (k % 2) != 0);
      chk("lit_alt_w1", m1_if.waitrequest, (k % 2) == 0);
      if (k > 0) begin
        if (k % 2) chk("lit_alt_d0", m0_if.readdata, 32'd11);
        else       chk("lit_alt_d1", m1_if.readdata, 32'd22);
        chk("lit_alt_v", (k % 2) ? m0_if.readdatavalid : m1_if.readdatavalid, 1);
      end
      step();
    end
    drv(0, 0, 0, 14'h0, 32'h0, 4'hF);
    drv(1, 0, 1, 14'h2800, 32'h1, 4'hF);
    @(negedge clk);
`ifdef SOC2_RAM_ARB_BOUNDS_CHECK_EN
    chk("lit_oor_wr_cs", ram_chipselect, 0);
`else
    chk("lit_oor_wr_cs", ram_chipselect, 1);
`endif
    step(); drv(1, 1, 0, 14'h2800, 32'h0, 4'hF);
    @(negedge clk);
    chk("lit_oor_rd_gnt", m1_if.waitrequest, 0);
    step(); drv(1, 0, 0, 14'h0, 32'h0, 4'hF);
    @(negedge clk);
    chk("lit_oor_rdv", m1_if.readdatavalid, 1);
`ifdef SOC2_RAM_ARB_BOUNDS_CHECK_EN
    chk("lit_oor_data", m1_if.readdata, OOR);
`else
    chk("lit_oor_data", m1_if.readdata, 32'h1);
`endif
    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
